// File: rtl/timer_pkg.sv
// Shared types and constants for the interval timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_RELOAD  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/timer_controller_tick_divider.sv
// Prescale counter: emits one tick every divide+1 enabled clocks.
module tick_divider #(
  parameter int unsigned PrescaleBits = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [PrescaleBits-1:0] divide,
  output logic                    tick
);

  logic [PrescaleBits-1:0] r_pcount;
  logic                    w_hit;

  assign w_hit = (r_pcount == divide);
  assign tick  = enable && w_hit;

  // Count 0..divide while enabled, wrapping on the tick; clear has priority.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_pcount <= '0;
    end else if (enable) begin
      if (w_hit) r_pcount <= '0;
      else       r_pcount <= r_pcount + PrescaleBits'(1);
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Programmable interval timer: config handshake, start/stop control,
// one-shot or auto-reload expiry around a Size-bit up-counter.
module timer_controller
  import timer_pkg::*;
#(
  parameter int unsigned Size         = 5,
  parameter int unsigned PrescaleBits = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [Size-1:0]         cfg_period,
  input  logic [PrescaleBits-1:0] cfg_prescale,
  input  logic                    cfg_oneshot,
  input  logic                    start,
  input  logic                    stop,
  output logic [Size-1:0]         count,
  output logic                    running,
  output logic                    expired
);

  state_t                  r_state;
  logic [Size-1:0]         r_count;
  logic [Size-1:0]         r_period;
  logic [PrescaleBits-1:0] r_prescale;
  logic                    r_oneshot;
  logic                    r_running;
  logic                    r_expired;

  logic w_cfg_fire;
  logic w_start_ok;
  logic w_stop_run;
  logic w_div_enable;
  logic w_div_clear;
  logic w_tick;

  // Config is only taken while the counter is not running.
  assign cfg_ready  = (r_state != RUN);
  assign w_cfg_fire = cfg_valid && cfg_ready;

  // A start is honoured only with a nonzero stored period, no stop, and no
  // config being written in the same cycle.
  assign w_start_ok = start && !stop && !w_cfg_fire && cfg_ready &&
                      (r_period != '0);
  assign w_stop_run = stop && (r_state == RUN);

  // Stop suppresses any coincident tick by gating the divider.
  assign w_div_enable = (r_state == RUN) && !stop;
  assign w_div_clear  = w_start_ok || w_stop_run;

  tick_divider #(
    .PrescaleBits(PrescaleBits)
  ) u_tick_divider (
    .clock  (clock),
    .reset  (reset),
    .enable (w_div_enable),
    .clear  (w_div_clear),
    .divide (r_prescale),
    .tick   (w_tick)
  );

  // Config registers latch on an accepted handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_period   <= '0;
      r_prescale <= '0;
      r_oneshot  <= MODE_RELOAD;
    end else if (w_cfg_fire) begin
      r_period   <= cfg_period;
      r_prescale <= cfg_prescale;
      r_oneshot  <= cfg_oneshot;
    end
  end

  // Timer FSM with registered count, running and expiry pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_state   <= RUN;
            r_count   <= '0;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else if (w_tick) begin
            if (r_count == r_period) begin
              r_expired <= 1'b1;
              if (r_oneshot == MODE_ONESHOT) begin
                r_state   <= DONE;
                r_running <= 1'b0;
              end else begin
                r_count <= '0;
              end
            end else begin
              r_count <= r_count + Size'(1);
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign expired = r_expired;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller: reload, one-shot, stop, config
// interlock, wrap at full-scale period and mid-run reset.
module tb_timer_controller;

  logic       clock;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_period;
  logic [3:0] cfg_prescale;
  logic       cfg_oneshot;
  logic       start;
  logic       stop;
  logic [4:0] count;
  logic       running;
  logic       expired;

  int total;
  int bad;

  timer_controller #(.Size(5), .PrescaleBits(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_oneshot  (cfg_oneshot),
    .start        (start),
    .stop         (stop),
    .count        (count),
    .running      (running),
    .expired      (expired)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input logic [4:0] p, input logic [3:0] s, input logic o);
    cfg_period = p; cfg_prescale = s; cfg_oneshot = o; cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%0b want=0", running); end
    total++; if (expired !== 1'b0) begin bad++; $display("FAIL reset_expired got=%0b want=0", expired); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%0b want=1", cfg_ready); end
  endtask

  task automatic test_zero_period_and_cfg_start();
    pulse_start();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL p0_start_running got=%0b want=0", running); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL p0_start_count got=%0d want=0", count); end
    cfg_period = 5'd4; cfg_prescale = 4'd0; cfg_oneshot = 1'b0;
    cfg_valid = 1'b1; start = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL cfg_start_same_cycle got=%0b want=0", running); end
    cyc();
    start = 1'b0;
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_after_cfg got=%0b want=1", running); end
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL run_cfg_ready got=%0b want=0", cfg_ready); end
    pulse_stop();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL p4_stop_running got=%0b want=0", running); end
  endtask

  task automatic test_reload();
    do_cfg(5'd3, 4'd0, 1'b0);
    pulse_start();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reload_start_count got=%0d want=0", count); end
    for (int k = 1; k <= 9; k++) begin
      cyc();
      total++;
      if (count !== 5'(k % 4) || expired !== (k % 4 == 0) || running !== 1'b1) begin
        bad++;
        $display("FAIL reload_step%0d got cnt=%0d exp=%0b run=%0b want cnt=%0d exp=%0b run=1",
                 k, count, expired, running, k % 4, (k % 4 == 0));
      end
    end
    pulse_stop();
  endtask

  task automatic test_oneshot();
    logic [4:0] exp_cnt [6];
    logic       exp_pulse [6];
    exp_cnt   = '{5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2};
    exp_pulse = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_cfg(5'd2, 4'd1, 1'b1);
    pulse_start();
    total++; if (count !== 5'd0 || running !== 1'b1) begin bad++; $display("FAIL oneshot_start got cnt=%0d run=%0b want cnt=0 run=1", count, running); end
    for (int k = 0; k < 6; k++) begin
      cyc();
      total++;
      if (count !== exp_cnt[k] || expired !== exp_pulse[k]) begin
        bad++;
        $display("FAIL oneshot_step%0d got cnt=%0d exp=%0b want cnt=%0d exp=%0b",
                 k + 1, count, expired, exp_cnt[k], exp_pulse[k]);
      end
    end
    total++; if (running !== 1'b0 || cfg_ready !== 1'b1) begin bad++; $display("FAIL oneshot_done got run=%0b rdy=%0b want run=0 rdy=1", running, cfg_ready); end
    cyc();
    total++; if (count !== 5'd2 || expired !== 1'b0) begin bad++; $display("FAIL oneshot_hold got cnt=%0d exp=%0b want cnt=2 exp=0", count, expired); end
    pulse_start();
    total++; if (count !== 5'd0 || running !== 1'b1) begin bad++; $display("FAIL oneshot_rearm got cnt=%0d run=%0b want cnt=0 run=1", count, running); end
    pulse_stop();
  endtask

  task automatic test_stop();
    do_cfg(5'd5, 4'd0, 1'b0);
    pulse_start();
    for (int k = 0; k < 5; k++) cyc();
    total++; if (count !== 5'd5) begin bad++; $display("FAIL stop_pre_count got=%0d want=5", count); end
    pulse_stop();
    total++; if (count !== 5'd5 || expired !== 1'b0 || running !== 1'b0) begin bad++; $display("FAIL stop_beats_tick got cnt=%0d exp=%0b run=%0b want cnt=5 exp=0 run=0", count, expired, running); end
    cyc();
    total++; if (count !== 5'd5 || expired !== 1'b0) begin bad++; $display("FAIL stop_idle_hold got cnt=%0d exp=%0b want cnt=5 exp=0", count, expired); end
    pulse_start();
    total++; if (count !== 5'd0 || running !== 1'b1) begin bad++; $display("FAIL stop_restart got cnt=%0d run=%0b want cnt=0 run=1", count, running); end
    cyc();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL stop_restart_step got=%0d want=1", count); end
    pulse_stop();
  endtask

  task automatic test_cfg_hold();
    // stored config is P=5, S=0, auto-reload
    pulse_start();
    cfg_period = 5'd7; cfg_prescale = 4'd3; cfg_oneshot = 1'b1; cfg_valid = 1'b1;
    #1;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL hold_cfg_ready got=%0b want=0", cfg_ready); end
    for (int k = 1; k <= 6; k++) begin
      cyc();
      total++;
      if (expired !== (k == 6) || count !== 5'(k % 6)) begin
        bad++;
        $display("FAIL hold_old_period_step%0d got cnt=%0d exp=%0b want cnt=%0d exp=%0b",
                 k, count, expired, k % 6, (k == 6));
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL hold_idle_ready got=%0b want=1", cfg_ready); end
    cyc();
    cfg_valid = 1'b0;
    pulse_start();
    for (int k = 0; k < 3; k++) cyc();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL hold_new_presc_pre got=%0d want=0", count); end
    cyc();
    total++; if (count !== 5'd1) begin bad++; $display("FAIL hold_new_presc_tick got=%0d want=1", count); end
    pulse_stop();
  endtask

  task automatic test_wrap_and_reset();
    do_cfg(5'd31, 4'd0, 1'b0);
    pulse_start();
    for (int k = 0; k < 30; k++) cyc();
    total++; if (count !== 5'd30) begin bad++; $display("FAIL wrap_30 got=%0d want=30", count); end
    cyc();
    total++; if (count !== 5'd31 || expired !== 1'b0) begin bad++; $display("FAIL wrap_31 got cnt=%0d exp=%0b want cnt=31 exp=0", count, expired); end
    cyc();
    total++; if (count !== 5'd0 || expired !== 1'b1 || running !== 1'b1) begin bad++; $display("FAIL wrap_0 got cnt=%0d exp=%0b run=%0b want cnt=0 exp=1 run=1", count, expired, running); end
    cyc();
    total++; if (count !== 5'd1 || expired !== 1'b0) begin bad++; $display("FAIL wrap_1 got cnt=%0d exp=%0b want cnt=1 exp=0", count, expired); end
    for (int k = 0; k < 16; k++) cyc();
    total++; if (count !== 5'd17) begin bad++; $display("FAIL wrap_17 got=%0d want=17", count); end
    reset = 1'b1; cyc(); reset = 1'b0;
    total++; if (count !== 5'd0 || running !== 1'b0 || expired !== 1'b0 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrun_reset got cnt=%0d run=%0b exp=%0b rdy=%0b want 0 0 0 1", count, running, expired, cfg_ready);
    end
    pulse_start();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_clears_period got=%0b want=0", running); end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; cfg_valid = 1'b0; cfg_period = '0;
    cfg_prescale = '0; cfg_oneshot = 1'b0; start = 1'b0; stop = 1'b0;
    total = 0; bad = 0;
    test_reset();
    test_zero_period_and_cfg_start();
    test_reload();
    test_oneshot();
    test_stop();
    test_cfg_hold();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_controller.md
Name: timer_controller

Overview:
Sequences a Size-bit up-counter as a programmable interval timer. Software-side logic loads the period, prescale and mode through a valid/ready config handshake, then starts and stops the timer. The block emits a one-cycle expiry pulse for one-shot or auto-reload operation. It sits between a register/config front-end and the counter datapath.

Parameters:
Size, 5, counter and period width in bits
PrescaleBits, 4, width of the clock-divide field

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  config may be accepted this cycle
cfg_period  input  Size  terminal count P
cfg_prescale  input  PrescaleBits  divide value S; one tick every S+1 clocks
cfg_oneshot  input  1  1 = one-shot, 0 = auto-reload
start  input  1  start request
stop  input  1  stop request
count  output  Size  current counter value
running  output  1  state == RUN
expired  output  1  one-cycle pulse at terminal count

Behaviour:
- One clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - state IDLE, count 0, running 0, expired 0, cfg_ready 1.
  - Internal period, prescale, oneshot and prescale counter all cleared to 0.
- States: IDLE, RUN, DONE. cfg_ready = 1 in IDLE and DONE, 0 in RUN. cfg_ready is combinational from state.
- Config handshake:
  - Accepted when cfg_valid && cfg_ready; the three fields are registered at that edge.
  - In RUN, cfg_valid is held off and has no effect.
- start, in IDLE or DONE:
  - Goes to RUN next edge, with count <= 0 and prescale counter <= 0.
  - Ignored if the stored period == 0 (stays in current state).
  - Ignored in the same cycle as an accepted config handshake.
  - Ignored in RUN (no restart).
- Prescaler:
  - Counts 0..S in RUN; tick is asserted when the prescale counter == S, and the counter then wraps to 0.
  - When S == 0, every RUN cycle ticks.
- On tick with count != P: count <= count + 1.
- On tick with count == P:
  - expired <= 1 for exactly one cycle.
  - Auto-reload: count <= 0 and stay in RUN.
  - One-shot: count holds at P and state goes to DONE.
- Latency: from the start edge, the first expired pulse follows (P+1)*(S+1) clocks later. Auto-reload repeats every (P+1)*(S+1) clocks.
- stop in RUN:
  - Goes to IDLE next edge; count holds its value; prescale counter is cleared.
  - stop beats a coincident tick: no increment and no expired pulse.
- stop in IDLE or DONE: no effect. If start and stop are both asserted, stop wins.
- DONE: count holds at P and running = 0. start re-arms from 0. Config may be reloaded.
- Wrap-around: count never exceeds P. When P = 2^Size - 1, the auto-reload transition is P -> 0 with no overflow carry.
- reset asserted mid-RUN: all reset values are applied at that edge, and any pending expiry is discarded.
- expired is registered and deasserts the cycle after it is set, unless a further terminal tick occurs. For P=0 no terminal tick can occur, because start is rejected.

Decomposition:
- Shared package timer_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - mode constants: MODE_RELOAD=1'b0, MODE_ONESHOT=1'b1.
- Sub-module tick_divider (parameter PrescaleBits):
  - Ports: clock, reset, enable, clear, divide, tick.
  - Implements the prescale counter.
- The FSM, config registers and count register remain in timer_controller.

Test Plan:
1. Config P=3, S=0, oneshot=0, then start -> count 0,1,2,3,0,1,... on successive edges; expired high on each 3->0 edge (every 4 clocks); running stays 1.
2. Config P=2, S=1, oneshot=1, then start -> count steps every 2 clocks: 0,0,1,1,2,2; expired single pulse 6 clocks after start; state DONE, count holds 2, running 0, cfg_ready 1.
3. Config P=5, S=0, start; assert stop in the cycle count==5 with a tick due -> no expired pulse, state IDLE, count stays 5; a later start restarts from 0.
4. Reset state (period 0), start -> stays IDLE, running 0, count 0. Then cfg_valid+start in the same cycle with P=4 -> config accepted, start ignored; start next cycle -> RUN.
5. In RUN, hold cfg_valid with P=7 -> cfg_ready 0, period unchanged (expiry timing still matches old P); after stop, the handshake completes on the first IDLE cycle.
6. Size=5, P=31, S=0, auto-reload -> count 30,31,0 with expired on 31->0. Assert reset at count=17 -> next cycle count 0, running 0, expired 0, cfg_ready 1.
